// File: rtl/idp_enc_11_seq_if.sv
// Handshake bundle between the data source, the 11-bit FNS encoder
// and the downstream 11-bit decoder stage.
`ifndef IBLEN11
`define IBLEN11 10
`endif

interface idp_enc_11_seq_if;
  logic                in_valid;
  logic                in_ready;
  logic [`IBLEN11-1:0] datain;
  logic                out_valid;
  logic                out_ready;
  logic [10:0]         codeout;
  logic                ovf;

  modport master (
    output in_valid,
    output datain,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  codeout,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  datain,
    input  out_ready,
    output in_ready,
    output out_valid,
    output codeout,
    output ovf
  );
endinterface

// File: rtl/idp_enc_11_seq.sv
// Sequential greedy encoder: binary word -> Mosaic 11-bit FNS codeword,
// one weight tried per clock, result held until the consumer takes it.
`ifndef IBLEN11
`define IBLEN11 10
`endif
`ifndef FNS01
`define FNS01 1
`endif
`ifndef FNS02
`define FNS02 2
`endif
`ifndef FNS03
`define FNS03 3
`endif
`ifndef FNS04
`define FNS04 5
`endif
`ifndef FNS05
`define FNS05 8
`endif
`ifndef FNS06
`define FNS06 13
`endif
`ifndef FNS07
`define FNS07 21
`endif
`ifndef FNS08
`define FNS08 34
`endif
`ifndef FNS09
`define FNS09 55
`endif
`ifndef FNS10
`define FNS10 89
`endif
`ifndef FNS11
`define FNS11 144
`endif

module idp_enc_11_seq (
  input logic             clk,
  input logic             rst,
  idp_enc_11_seq_if.slave bus
);
  localparam int W = `IBLEN11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_nxt;
  logic [W-1:0]   r_rem;
  logic [10:0]    r_code;
  logic [3:0]     r_step;
  logic           r_ovf;

  logic [W-1:0]   w_wt;
  logic [W-1:0]   w_diff;
  logic [W-1:0]   w_rem_nxt;
  logic [10:0]    w_mask;
  logic           w_take;
  logic           w_last;
  logic           w_in_ready;
  logic           w_out_valid;

  // Step order tries the duplicated top weight twice before bit10.
  always_comb begin
    w_wt   = '0;
    w_mask = '0;
    unique case (r_step)
      4'd0: begin
        w_wt   = W'(`FNS11);
        w_mask = 11'b010_0000_0000;
      end
      4'd1: begin
        w_wt   = W'(`FNS11);
        w_mask = 11'b001_0000_0000;
      end
      4'd2: begin
        w_wt   = W'(`FNS10);
        w_mask = 11'b100_0000_0000;
      end
      4'd3: begin
        w_wt   = W'(`FNS08);
        w_mask = 11'b000_1000_0000;
      end
      4'd4: begin
        w_wt   = W'(`FNS07);
        w_mask = 11'b000_0100_0000;
      end
      4'd5: begin
        w_wt   = W'(`FNS06);
        w_mask = 11'b000_0010_0000;
      end
      4'd6: begin
        w_wt   = W'(`FNS05);
        w_mask = 11'b000_0001_0000;
      end
      4'd7: begin
        w_wt   = W'(`FNS04);
        w_mask = 11'b000_0000_1000;
      end
      4'd8: begin
        w_wt   = W'(`FNS03);
        w_mask = 11'b000_0000_0100;
      end
      4'd9: begin
        w_wt   = W'(`FNS02);
        w_mask = 11'b000_0000_0010;
      end
      4'd10: begin
        w_wt   = W'(`FNS01);
        w_mask = 11'b000_0000_0001;
      end
      default: begin
        w_wt   = '0;
        w_mask = '0;
      end
    endcase
  end

  always_comb begin
    w_take    = (r_rem >= w_wt);
    w_diff    = r_rem - w_wt;
    w_rem_nxt = w_take ? w_diff : r_rem;
    w_last    = (r_step == 4'd10);
  end

  always_comb begin
    w_nxt       = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = ~rst;
        if (bus.in_valid)
          w_nxt = RUN;
      end
      RUN: begin
        if (w_last)
          w_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready)
          w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.codeout   = r_code;
  assign bus.ovf       = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_code  <= '0;
      r_step  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_rem  <= bus.datain;
            r_code <= '0;
            r_step <= '0;
            r_ovf  <= 1'b0;
          end
        end
        RUN: begin
          r_rem  <= w_rem_nxt;
          r_step <= r_step + 4'd1;
          if (w_take)
            r_code <= r_code | w_mask;
          // Anything left after the last weight was not representable.
          if (w_last)
            r_ovf <= (w_rem_nxt != '0);
        end
        DONE: begin
          r_rem <= r_rem;
        end
        default: begin
          r_rem <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_idp_enc_11_seq.sv
// Bench for idp_enc_11_seq: directed steps plus random words checked
// against a greedy arithmetic model of the FNS encoding.
`ifndef IBLEN11
`define IBLEN11 10
`endif
`ifndef FNS01
`define FNS01 1
`endif
`ifndef FNS02
`define FNS02 2
`endif
`ifndef FNS03
`define FNS03 3
`endif
`ifndef FNS04
`define FNS04 5
`endif
`ifndef FNS05
`define FNS05 8
`endif
`ifndef FNS06
`define FNS06 13
`endif
`ifndef FNS07
`define FNS07 21
`endif
`ifndef FNS08
`define FNS08 34
`endif
`ifndef FNS09
`define FNS09 55
`endif
`ifndef FNS10
`define FNS10 89
`endif
`ifndef FNS11
`define FNS11 144
`endif

module tb_idp_enc_11_seq;
  localparam int W = `IBLEN11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  idp_enc_11_seq_if bus ();

  idp_enc_11_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic int wt(input int b);
    case (b)
      10: return `FNS10;
      9:  return `FNS11;
      8:  return `FNS11;
      7:  return `FNS08;
      6:  return `FNS07;
      5:  return `FNS06;
      4:  return `FNS05;
      3:  return `FNS04;
      2:  return `FNS03;
      1:  return `FNS02;
      0:  return `FNS01;
      default: return 0;
    endcase
  endfunction

  function automatic void model(input int d, output logic [10:0] c,
                                output logic o);
    int ord [11];
    int r;
    ord = '{9, 8, 10, 7, 6, 5, 4, 3, 2, 1, 0};
    r = d;
    c = '0;
    foreach (ord[i]) begin
      if (r >= wt(ord[i])) begin
        c[ord[i]] = 1'b1;
        r -= wt(ord[i]);
      end
    end
    o = (r != 0);
  endfunction

  function automatic int decode(input logic [10:0] c);
    int s = 0;
    for (int b = 0; b < 11; b++)
      if (c[b]) s += wt(b);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic encode(input int d, input int hold, input bit pulse);
    int n;
    logic [10:0] ec;
    logic eo;
    model(d, ec, eo);
    n = 0;
    while (!bus.in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("rdy_wait", 32'(n < 40), 32'd1);
    bus.datain   = W'(d);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 30) begin
      bus.out_ready = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      n++;
    end
    bus.out_ready = 1'b0;
    chk("latency", 32'(n), 32'd12);
    chk("code", 32'(bus.codeout), 32'(ec));
    chk("ovf", 32'(bus.ovf), 32'(eo));
    if (!eo)
      chk("roundtrip", 32'(decode(bus.codeout)), 32'(d));
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.datain   = W'($urandom);
      tick();
      chk("bp_hold", {19'd0, bus.out_valid, bus.in_ready, bus.ovf,
                      bus.codeout},
          {19'd0, 1'b1, 1'b0, eo, ec});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("consume", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
  endtask

  initial begin
    int sum;
    int n;
    int nacc;
    int pos [$];
    bus.in_valid  = 1'b0;
    bus.datain    = '0;
    bus.out_ready = 1'b0;
    sum = 0;
    for (int b = 0; b < 11; b++)
      sum += wt(b);

    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_code", 32'(bus.codeout), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    encode(0, 0, 1'b1);
    encode(2 * `FNS11, 0, 1'b0);
    chk("dup_top", 32'(bus.codeout), 32'h300);
    encode(`FNS11, 0, 1'b1);
    chk("one_top", 32'(bus.codeout), 32'h200);
    encode(sum + 1, 0, 1'b0);
    chk("ovf_sum1", 32'(bus.ovf), 32'd1);

    encode(300, 20, 1'b0);

    bus.datain   = W'(377);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(bus.in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_code", 32'(bus.codeout), 32'd0);
    chk("mid_rst_rdy1", 32'(bus.in_ready), 32'd1);
    n = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.out_valid) n++;
      tick();
    end
    chk("mid_rst_noval", 32'(n), 32'd0);
    encode(377, 0, 1'b0);

    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    nacc = 0;
    for (int k = 0; k < 41; k++) begin
      bus.datain = W'($urandom);
      #1;
      if (bus.in_ready) begin
        nacc++;
        pos.push_back(k);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("accept_cnt", 32'(nacc), 32'd4);
    for (int i = 1; i < pos.size(); i++)
      chk("accept_gap", 32'(pos[i] - pos[i-1]), 32'd13);
    n = 0;
    while (!bus.in_ready && n < 30) begin
      tick();
      n++;
    end
    chk("drain", 32'(n < 30), 32'd1);
    bus.out_ready = 1'b0;

    for (int d = 0; d <= sum + 1; d++)
      encode(d, 0, 1'b0);
    for (int k = 0; k < 30; k++)
      encode(int'($urandom_range(0, (1 << W) - 1)), 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
